// File: rtl/fpm_seq_mul_core.sv
// Sequential IEEE-754 single-precision multiplier (shift-add mantissa, STEP bits per cycle).
// Latency: out_valid high N+2 cycles after accept (N = 24/STEP); special operands 1 cycle.
// Backpressure: result and flags held in DONE until out_ready; in_ready only in IDLE.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   operand handshake (a, b sampled on accept)
//   a, b                  single-precision operands
//   out_valid / out_ready result handshake
//   result                single-precision product
//   overflow, underflow, invalid  exception flags, valid with out_valid
//
// Build option: define FPM_RNE_ROUND_EN for round-to-nearest-even; otherwise truncate.
module fpm_seq_mul_core #(
    parameter int STEP = 1          // multiplier bits retired per MUL cycle: 1, 2 or 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        invalid
);

    localparam int         N    = 24 / STEP;
    localparam logic [4:0] LAST = 5'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_NORM,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        in_ready_q, in_ready_d;
    logic        sign_q, sign_d;
    logic [9:0]  exp_q, exp_d;        // two's-complement biased exponent
    logic [23:0] ma_q, ma_d;
    logic [23:0] mb_q, mb_d;
    logic [47:0] prod_q, prod_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;
    logic        inv_q, inv_d;

    // ---------------- operand classification ----------------
    logic a_zero, a_inf, a_nan;
    logic b_zero, b_inf, b_nan;
    logic op_sign;

    assign a_zero  = (a[30:23] == 8'h00);
    assign b_zero  = (b[30:23] == 8'h00);
    assign a_inf   = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    assign b_inf   = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    assign a_nan   = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    assign b_nan   = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    assign op_sign = a[31] ^ b[31];

    // ---------------- shift-add partial product ----------------
    // The multiplier is consumed MSB-first, so the accumulator shifts left
    // each iteration and ends holding the full 48-bit product.
    logic [STEP-1:0] digit;
    logic [47:0]     pp;

    assign digit = mb_q[23 -: STEP];

    always_comb begin
        pp = '0;
        for (int i = 0; i < STEP; i++) begin
            if (digit[i]) begin
                pp = pp + (48'(ma_q) << i);
            end
        end
    end

    // ---------------- normalisation and rounding ----------------
    logic        p_top;
    logic [22:0] frac_n;
    logic [9:0]  exp_n;
    logic        round_up;
    logic [23:0] frac_rnd;            // {carry, fraction}
    logic [9:0]  exp_fin;
    logic        is_ovf, is_unf;

    assign p_top  = prod_q[47];
    assign frac_n = p_top ? prod_q[46:24] : prod_q[45:23];
    assign exp_n  = exp_q + {9'd0, p_top};

`ifdef FPM_RNE_ROUND_EN
    logic guard, sticky;
    assign guard    = p_top ? prod_q[23] : prod_q[22];
    assign sticky   = p_top ? (|prod_q[22:0]) : (|prod_q[21:0]);
    assign round_up = guard & (sticky | frac_n[0]);
`else
    assign round_up = 1'b0;
`endif

    // A carry out of the fraction leaves frac_rnd[22:0] at zero already.
    assign frac_rnd = {1'b0, frac_n} + {23'd0, round_up};
    assign exp_fin  = exp_n + {9'd0, frac_rnd[23]};
    assign is_ovf   = ($signed(exp_fin) >= 10'sd255);
    assign is_unf   = ($signed(exp_fin) <= 10'sd0);

    // ---------------- next-state / datapath ----------------
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inv_d    = inv_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    sign_d = op_sign;
                    ovf_d  = 1'b0;
                    unf_d  = 1'b0;
                    inv_d  = 1'b0;
                    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
                        result_d = 32'h7FC0_0000;
                        inv_d    = 1'b1;
                        state_d  = S_DONE;
                    end else if (a_inf || b_inf) begin
                        result_d = {op_sign, 8'hFF, 23'd0};
                        state_d  = S_DONE;
                    end else if (a_zero || b_zero) begin
                        // exponent field 0 covers subnormals too: flushed to zero
                        result_d = {op_sign, 31'd0};
                        state_d  = S_DONE;
                    end else begin
                        exp_d   = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
                        ma_d    = {1'b1, a[22:0]};
                        mb_d    = {1'b1, b[22:0]};
                        prod_d  = '0;
                        cnt_d   = '0;
                        state_d = S_MUL;
                    end
                end
            end
            S_MUL: begin
                prod_d = (prod_q << STEP) + pp;
                mb_d   = mb_q << STEP;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == LAST) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (is_ovf) begin
                    result_d = {sign_q, 8'hFF, 23'd0};
                    ovf_d    = 1'b1;
                end else if (is_unf) begin
                    result_d = {sign_q, 31'd0};
                    unf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, exp_fin[7:0], frac_rnd[22:0]};
                end
                exp_d   = exp_fin;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered ready: low through reset and for the handshake cycle,
        // so there is never a same-cycle re-accept.
        in_ready_d = (state_d == S_IDLE);
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q   <= 1'b0;
            exp_q    <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inv_q    <= inv_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign invalid   = inv_q;

endmodule

// File: doc/fpm_seq_mul_core.md
FPM_SEQ_MUL_CORE -- requirements
Module: fpm_seq_mul_core

Interface
REQ-001 The block SHALL have parameter STEP, default 1: multiplier bits retired per MUL cycle; legal values 1, 2, 4; N = 24/STEP iterations.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operands a, b are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 The block SHALL have ports a and b, input, 32 bits each: IEEE-754 single-precision operands.
REQ-007 The block SHALL have port out_valid, output, 1 bit: result and flags are valid.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-009 The block SHALL have port result, output, 32 bits: single-precision product.
REQ-010 The block SHALL have ports overflow, underflow and invalid, output, 1 bit each: exception flags, valid with out_valid.

Function
REQ-011 The block SHALL implement FSM states IDLE, MUL, NORM and DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-012 On accept (in_valid&in_ready) the block SHALL register sign=a[31]^b[31], a 10-bit signed exponent sum ea+eb-127, and 24-bit mantissas with hidden bit set.
REQ-013 Exponent field 0 (zero or subnormal) SHALL be treated as signed zero, with no subnormal support.
REQ-014 Special cases SHALL bypass MUL and reach DONE on the edge after accept: any NaN or inf*0 -> 0x7FC00000 with invalid=1; inf*nonzero -> signed inf; zero*finite -> signed zero.
REQ-015 MUL SHALL run exactly N cycles of shift-add, forming a 48-bit product P = ma*mb, then move to NORM.
REQ-016 NORM (1 cycle) SHALL act as follows: if P[47]=1, fraction=P[46:24], guard=P[23], sticky=|P[22:0], exponent+1; else fraction=P[45:23], guard=P[22], sticky=|P[21:0].
REQ-017 A mantissa carry-out from rounding SHALL increment the exponent and zero the fraction.
REQ-018 If the final biased exponent is >=255, the block SHALL return signed inf (0x7F800000|sign) with overflow=1; if it is <=0, signed zero with underflow=1.
REQ-019 Output latency SHALL be: out_valid rises N+2 cycles after the accept edge for normal operands; 1 cycle after it for special cases.
REQ-020 DONE SHALL hold result and flags stable until out_ready=1; on out_valid&out_ready the block SHALL return to IDLE, and in_ready SHALL be 1 on the next cycle (no same-cycle re-accept).
REQ-021 Inputs a, b and in_valid SHALL be ignored outside IDLE.

Reset
REQ-022 rst_n=0 SHALL immediately force the state to IDLE and set result=0, out_valid=0, overflow=0, underflow=0, invalid=0, in_ready=0 while asserted; the internal product and exponent registers SHALL clear to 0.
REQ-023 Reset asserted mid-MUL or in DONE SHALL discard the operation with no output produced, and in_ready SHALL be 1 on the first clock edge after release.

Configuration
REQ-024 With FPM_RNE_ROUND_EN defined, the fraction SHALL round to nearest, ties to even: increment when guard&(sticky|fraction[0]).
REQ-025 Without FPM_RNE_ROUND_EN, the fraction SHALL be truncated (guard and sticky discarded), and REQ-017 is then unreachable; latency is identical in both builds.

Verification
REQ-026 Scenario: STEP=1, a=0x3FC00000, b=0x40000000 -> result 0x40400000, all flags 0, out_valid 26 cycles after accept.
REQ-027 Scenario: a=0x3FC00000, b=0x3F800001 -> result 0x3FC00002 with FPM_RNE_ROUND_EN defined, 0x3FC00001 without it.
REQ-028 Scenario: a=0x7F000000, b=0x7F000000 -> result 0x7F800000, overflow=1; a=0x00800000, b=0x00800000 -> result 0x00000000, underflow=1.
REQ-029 Scenario: a=0x7F800000, b=0x80000000 -> result 0x7FC00000, invalid=1, out_valid 1 cycle after accept.
REQ-030 Scenario: hold out_ready=0 for 10 cycles in DONE -> result stable, in_ready=0, a new in_valid is ignored; then out_ready=1 -> IDLE, and the next op is accepted one cycle later.
REQ-031 Scenario: assert rst_n=0 at MUL cycle 5 -> all outputs 0 immediately; after release in_ready=1 and the next op 0x40000000*0x40000000 gives 0x40800000.
